unified_memory_arbiter: RTL and testbench

Shares one single-ported instruction/data memory between the compute core's instruction-fetch port and its load/store port, so a core variant can run from a single `vectorStorage` instance instead of split instruction and data memories. Each cycle it grants the memory to one requester. It tracks the one-cycle synchronous-read response and routes it back to the correct requester. Data accesses have priority, bounded by an anti-starvation counter that guarantees fetch progress.

---
 rtl/unified_memory_arbiter.sv | 117 +++++++++++
 tb/tb_unified_memory_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module unified_memory_arbiter #(
  parameter int unsigned BIT_COUNT    = 32,
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   FetchReq,
  input  logic [BIT_COUNT-1:0]   FetchAdr,
  output logic                   FetchGnt,
  output logic                   FetchValid,
  output logic [WORD_SIZE-1:0]   FetchData,
  input  logic                   DataReq,
  input  logic                   DataWrite,
  input  logic [BIT_COUNT-1:0]   DataAdr,
  input  logic [WORD_SIZE/8-1:0] DataByteEn,
  input  logic [WORD_SIZE-1:0]   DataWriteData,
  output logic                   DataGnt,
  output logic                   DataValid,
  output logic [WORD_SIZE-1:0]   DataReadData,
  output logic                   MemEn,
  output logic                   MemWrite,
  output logic [BIT_COUNT-1:0]   MemAdr,
  output logic [WORD_SIZE/8-1:0] MemByteEn,
  output logic [WORD_SIZE-1:0]   MemWriteData,
  input  logic [WORD_SIZE-1:0]   MemReadData
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  localparam logic [1:0] RespNone   = 2'd0;
  localparam logic [1:0] RespFetch  = 2'd1;
  localparam logic [1:0] RespDataRd = 2'd2;
  localparam logic [1:0] RespDataWr = 2'd3;

  logic [1:0]           resp_owner_q, resp_owner_d;
  logic [CntW-1:0]      starve_cnt_q, starve_cnt_d;
  logic [WORD_SIZE-1:0] fetch_hold_q, fetch_hold_d;
  logic [WORD_SIZE-1:0] data_hold_q, data_hold_d;
  logic                 fetch_gnt, data_gnt;

  // Grants are gated by reset so the memory port goes quiet without waiting for an edge.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (reset) begin
      if (FetchReq && DataReq) begin
        if (starve_cnt_q == StarveMax) fetch_gnt = 1'b1;
        else                           data_gnt  = 1'b1;
      end else begin
        fetch_gnt = FetchReq;
        data_gnt  = DataReq;
      end
    end
  end

  assign FetchGnt = fetch_gnt;
  assign DataGnt  = data_gnt;

  always_comb begin
    MemEn        = fetch_gnt | data_gnt;
    MemWrite     = 1'b0;
    MemAdr       = '0;
    MemByteEn    = '0;
    MemWriteData = '0;
    if (data_gnt) begin
      MemWrite     = DataWrite;
      MemAdr       = DataAdr;
      MemByteEn    = DataByteEn;
      MemWriteData = DataWriteData;
    end else if (fetch_gnt) begin
      MemAdr = FetchAdr;
    end
  end

  always_comb begin
    resp_owner_d = RespNone;
    if (fetch_gnt)     resp_owner_d = RespFetch;
    else if (data_gnt) resp_owner_d = DataWrite ? RespDataWr : RespDataRd;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fetch_gnt || !FetchReq) begin
      starve_cnt_d = '0;
    end else if (data_gnt && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign fetch_hold_d = (resp_owner_q == RespFetch)  ? MemReadData : fetch_hold_q;
  assign data_hold_d  = (resp_owner_q == RespDataRd) ? MemReadData : data_hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_owner_q <= RespNone;
      starve_cnt_q <= '0;
      fetch_hold_q <= '0;
      data_hold_q  <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      fetch_hold_q <= fetch_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

  // Read data is passed straight through in the response cycle, hold register otherwise.
  assign FetchValid   = (resp_owner_q == RespFetch);
  assign FetchData    = FetchValid ? MemReadData : fetch_hold_q;
  assign DataValid    = (resp_owner_q == RespDataRd) || (resp_owner_q == RespDataWr);
  assign DataReadData = (resp_owner_q == RespDataRd) ? MemReadData : data_hold_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter with a behavioural synchronous memory and
// response scoreboards for the fetch and data ports.
module tb_unified_memory_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] d;
  } resp_t;

  logic        clk, reset;
  logic        FetchReq, FetchGnt, FetchValid;
  logic [31:0] FetchAdr, FetchData;
  logic        DataReq, DataWrite, DataGnt, DataValid;
  logic [31:0] DataAdr, DataWriteData, DataReadData;
  logic [3:0]  DataByteEn;
  logic        MemEn, MemWrite;
  logic [31:0] MemAdr, MemWriteData, MemReadData;
  logic [3:0]  MemByteEn;

  logic [31:0] mem [0:63];
  logic [31:0] fq [$];
  resp_t       dq [$];
  logic        fv_exp, dv_exp;
  logic [31:0] fhold, dhold;
  int          n_tests, n_fail;

  unified_memory_arbiter #(
    .BIT_COUNT(32), .WORD_SIZE(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .FetchReq(FetchReq), .FetchAdr(FetchAdr), .FetchGnt(FetchGnt),
    .FetchValid(FetchValid), .FetchData(FetchData),
    .DataReq(DataReq), .DataWrite(DataWrite), .DataAdr(DataAdr), .DataByteEn(DataByteEn),
    .DataWriteData(DataWriteData), .DataGnt(DataGnt), .DataValid(DataValid),
    .DataReadData(DataReadData),
    .MemEn(MemEn), .MemWrite(MemWrite), .MemAdr(MemAdr), .MemByteEn(MemByteEn),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-ported memory: byte-lane writes, one-cycle registered read.
  always @(posedge clk) begin
    if (MemEn) begin
      if (MemWrite) begin
        for (int b = 0; b < 4; b++)
          if (MemByteEn[b]) mem[MemAdr[7:2]][8*b +: 8] <= MemWriteData[8*b +: 8];
      end else begin
        MemReadData <= mem[MemAdr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive requests, check grants and memory drive, check responses.
  task automatic cycle(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd,
                       input logic eg_f, input logic eg_d,
                       input logic [31:0] fexp, input logic [31:0] dexp);
    resp_t r;
    FetchReq = fr; FetchAdr = fa; DataReq = dr; DataWrite = dw;
    DataAdr = da; DataByteEn = be; DataWriteData = wd;
    #3;
    chk("fetch_gnt", {31'b0, FetchGnt}, {31'b0, eg_f});
    chk("data_gnt", {31'b0, DataGnt}, {31'b0, eg_d});
    chk("mem_en", {31'b0, MemEn}, {31'b0, eg_f | eg_d});
    if (eg_f) begin
      chk("mem_adr_fetch", MemAdr, fa);
      chk("mem_write_fetch", {31'b0, MemWrite}, 32'd0);
      chk("mem_be_fetch", {28'b0, MemByteEn}, 32'd0);
    end
    if (eg_d) begin
      chk("mem_adr_data", MemAdr, da);
      chk("mem_write_data", {31'b0, MemWrite}, {31'b0, dw});
      chk("mem_be_data", {28'b0, MemByteEn}, {28'b0, be});
      if (dw) chk("mem_wdata", MemWriteData, wd);
    end
    chk("fetch_valid", {31'b0, FetchValid}, {31'b0, fv_exp});
    if (FetchValid && fq.size() > 0) fhold = fq.pop_front();
    chk("fetch_data", FetchData, fhold);
    chk("data_valid", {31'b0, DataValid}, {31'b0, dv_exp});
    if (DataValid && dq.size() > 0) begin
      r = dq.pop_front();
      if (!r.wr) dhold = r.d;
    end
    chk("data_rdata", DataReadData, dhold);
    fv_exp = eg_f;
    dv_exp = eg_d;
    if (eg_f) fq.push_back(fexp);
    if (eg_d) dq.push_back('{wr: dw, d: dexp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    fv_exp = 1'b0; dv_exp = 1'b0; fhold = '0; dhold = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 32'h0000_0013;
    mem[1]  = 32'h0010_0113;
    mem[2]  = 32'h0050_0093;
    mem[16] = 32'h1234_5678;
    MemReadData = 32'hA5A5_A5A5;
    reset = 1'b0;
    FetchReq = 1'b1; FetchAdr = 32'h8; DataReq = 1'b1; DataWrite = 1'b0;
    DataAdr = 32'h40; DataByteEn = 4'h0; DataWriteData = '0;

    // Reset state with requests pending: everything quiet.
    #3;
    chk("rst_fetch_gnt", {31'b0, FetchGnt}, 32'd0);
    chk("rst_data_gnt", {31'b0, DataGnt}, 32'd0);
    chk("rst_mem_en", {31'b0, MemEn}, 32'd0);
    chk("rst_mem_adr", MemAdr, 32'd0);
    chk("rst_fetch_valid", {31'b0, FetchValid}, 32'd0);
    chk("rst_data_valid", {31'b0, DataValid}, 32'd0);
    chk("rst_fetch_data", FetchData, 32'd0);
    chk("rst_data_rdata", DataReadData, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Async reset mid-traffic while FetchValid is high.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    FetchReq = 1'b1; FetchAdr = 32'h4; DataReq = 1'b0;
    #1;
    chk("pre_rst_fetch_valid", {31'b0, FetchValid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_fetch_valid", {31'b0, FetchValid}, 32'd0);
    chk("mid_rst_fetch_data", FetchData, 32'd0);
    chk("mid_rst_fetch_gnt", {31'b0, FetchGnt}, 32'd0);
    chk("mid_rst_mem_en", {31'b0, MemEn}, 32'd0);
    chk("mid_rst_mem_adr", MemAdr, 32'd0);
    fq.delete(); dq.delete();
    fv_exp = 1'b0; dv_exp = 1'b0; fhold = '0; dhold = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle();
    idle();

    // Single fetch, then the word must persist in the hold register.
    cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0050_0093, 32'h0);
    idle();
    idle();

    // Contention: data wins, fetch follows, back to back.
    cycle(1'b1, 32'h4, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0010_0113, 32'h0);
    idle();

    // Starvation: D,D,D,D,F repeating.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, (i % 5) == 4, (i % 5) != 4,
            32'h0000_0013, 32'h1234_5678);
    idle();

    // Fetch aborts exactly when the limit is reached: data granted, counter clears.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    idle();

    // Byte store of the low half-word, then read it back.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0000_BEEF);
    idle();

    // Pipelined fetches on consecutive cycles.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0010_0113, 32'h0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0050_0093, 32'h0);
    idle();
    idle();

    chk("fetch_queue_drained", fq.size(), 32'd0);
    chk("data_queue_drained", dq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
